// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - multi-channel programmable LED pattern generator
// Shared prescaler tick drives per-channel OFF/ON/BLINK/BURST pattern state.
module led_sequencer #(
  parameter int CLK_HZ   = 40000000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_LEDS = 4,
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 4,
  parameter int CH_W     = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                WR_EN,
  input  logic [CH_W-1:0]     WR_CH,
  input  logic [1:0]          WR_MODE,
  input  logic [PERIOD_W-1:0] WR_PERIOD,
  input  logic [COUNT_W-1:0]  WR_COUNT,
  output logic [NUM_LEDS-1:0] LED,
  output logic                TICK
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GAP_W = PERIOD_W + 2;
  localparam int FC_W  = COUNT_W + 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_BURST} mode_t;
  typedef enum logic [1:0] {S_ON, S_OFF, S_GAP} state_t;

  logic [PS_W-1:0]     ps_cnt;
  mode_t               mode   [NUM_LEDS];
  logic [PERIOD_W-1:0] period [NUM_LEDS];
  logic [COUNT_W-1:0]  count  [NUM_LEDS];
  logic [GAP_W-1:0]    phase  [NUM_LEDS];
  logic [COUNT_W-1:0]  flash  [NUM_LEDS];
  state_t              state  [NUM_LEDS];

  logic [GAP_W-1:0]    on_last  [NUM_LEDS];
  logic [GAP_W-1:0]    gap_last [NUM_LEDS];
  logic [NUM_LEDS-1:0] wr_hit;

  // Phase compare points are widened so period = 2**PERIOD_W-1 and 4*period never wrap.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      on_last[i]  = GAP_W'(period[i]) - GAP_W'(1);
      gap_last[i] = {period[i], 2'b00} - GAP_W'(1);
      wr_hit[i]   = WR_EN && (WR_CH == CH_W'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ps_cnt <= '0;
      TICK   <= 1'b0;
      LED    <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode[i]   <= M_OFF;
        period[i] <= PERIOD_W'(1);
        count[i]  <= '0;
        phase[i]  <= '0;
        flash[i]  <= '0;
        state[i]  <= S_ON;
      end
    end else begin
      ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
      TICK   <= (ps_cnt == PS_LAST);

      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_hit[i]) begin
          // A write restarts the pattern and takes priority over a coincident tick.
          mode[i]   <= mode_t'(WR_MODE);
          period[i] <= (WR_PERIOD == '0) ? PERIOD_W'(1) : WR_PERIOD;
          count[i]  <= WR_COUNT;
          phase[i]  <= '0;
          flash[i]  <= '0;
          state[i]  <= S_ON;
          case (mode_t'(WR_MODE))
            M_OFF:   LED[i] <= 1'b0;
            M_BURST: LED[i] <= (WR_COUNT != '0);
            default: LED[i] <= 1'b1;
          endcase
        end else if (TICK) begin
          case (mode[i])
            M_BLINK: begin
              if (phase[i] == on_last[i]) begin
                phase[i] <= '0;
                state[i] <= (state[i] == S_ON) ? S_OFF : S_ON;
                LED[i]   <= (state[i] != S_ON);
              end else begin
                phase[i] <= phase[i] + GAP_W'(1);
              end
            end
            M_BURST: begin
              if (count[i] != '0) begin
                case (state[i])
                  S_ON: begin
                    if (phase[i] == on_last[i]) begin
                      phase[i] <= '0;
                      flash[i] <= flash[i] + COUNT_W'(1);
                      LED[i]   <= 1'b0;
                      if (FC_W'(flash[i]) + FC_W'(1) == FC_W'(count[i]))
                        state[i] <= S_GAP;
                      else
                        state[i] <= S_OFF;
                    end else begin
                      phase[i] <= phase[i] + GAP_W'(1);
                    end
                  end
                  S_OFF: begin
                    if (phase[i] == on_last[i]) begin
                      phase[i] <= '0;
                      state[i] <= S_ON;
                      LED[i]   <= 1'b1;
                    end else begin
                      phase[i] <= phase[i] + GAP_W'(1);
                    end
                  end
                  default: begin
                    if (phase[i] == gap_last[i]) begin
                      phase[i] <= '0;
                      flash[i] <= '0;
                      state[i] <= S_ON;
                      LED[i]   <= 1'b1;
                    end else begin
                      phase[i] <= phase[i] + GAP_W'(1);
                    end
                  end
                endcase
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - bench for led_sequencer
// Pattern-position reference model feeds a per-cycle scoreboard; vectors and tick-sampled sequences add corner checks.
module tb_led_sequencer;

  localparam int NL  = 4;
  localparam int PW  = 16;
  localparam int CW  = 4;
  localparam int CHW = 3;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [CHW-1:0] wr_ch = '0;
  logic [1:0]    wr_mode = '0;
  logic [PW-1:0] wr_period = '0;
  logic [CW-1:0] wr_count = '0;
  logic [NL-1:0] led;
  logic          tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_sequencer #(
    .CLK_HZ(40), .TICK_HZ(10), .NUM_LEDS(NL), .PERIOD_W(PW), .COUNT_W(CW), .CH_W(CHW)
  ) dut (
    .CLK(clk), .RESET(rst), .WR_EN(wr_en), .WR_CH(wr_ch), .WR_MODE(wr_mode),
    .WR_PERIOD(wr_period), .WR_COUNT(wr_count), .LED(led), .TICK(tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected LED from ticks elapsed since the last write, using the pattern's cycle layout.
  function automatic logic exp_led(input int mode, input int per, input int cnt, input int t);
    int pos;
    case (mode)
      1: return 1'b1;
      2: return ((t / per) % 2) == 0;
      3: begin
        if (cnt == 0) return 1'b0;
        pos = t % ((2 * cnt + 3) * per);
        return (pos < (2 * cnt - 1) * per) && (((pos / per) % 2) == 0);
      end
      default: return 1'b0;
    endcase
  endfunction

  logic [4:0] sb[$];
  int   m_cnt = 0;
  logic m_tick = 1'b0;
  int   m_mode[NL];
  int   m_per[NL];
  int   m_cntf[NL];
  int   m_t[NL];

  always @(posedge clk) begin
    logic [4:0] e;
    if (rst) begin
      m_cnt  = 0;
      m_tick = 1'b0;
      for (int c = 0; c < NL; c++) begin
        m_mode[c] = 0; m_per[c] = 1; m_cntf[c] = 0; m_t[c] = 0;
      end
    end else begin
      for (int c = 0; c < NL; c++) begin
        if (wr_en && int'(wr_ch) == c) begin
          m_mode[c] = int'(wr_mode);
          m_per[c]  = (wr_period == '0) ? 1 : int'(wr_period);
          m_cntf[c] = int'(wr_count);
          m_t[c]    = 0;
        end else if (m_tick) begin
          m_t[c]++;
        end
      end
      m_tick = (m_cnt == DIV - 1);
      m_cnt  = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
    end
    for (int c = 0; c < NL; c++) e[c] = exp_led(m_mode[c], m_per[c], m_cntf[c], m_t[c]);
    e[4] = m_tick;
    sb.push_back(e);
  end

  always @(negedge clk) begin
    logic [4:0] g;
    if (sb.size() > 0) begin
      g = sb.pop_front();
      chk("sb_led", 32'(led), 32'(g[3:0]));
      chk("sb_tick", 32'(tick), 32'(g[4]));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input int ch, input int mode, input int per, input int cnt);
    wr_ch = CHW'(ch); wr_mode = 2'(mode); wr_period = PW'(per); wr_count = CW'(cnt);
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int g;
    g = 0;
    while (!tick && g < 3 * DIV) begin step(); g++; end
    if (!tick) chk({name, "_tick_timeout"}, 32'(tick), 32'd1);
  endtask

  // Sample one channel at each tick-pending cycle; pat bit k is the expected LED at sample k.
  task automatic sample_ticks(input string name, input int ch, input int n, input logic [31:0] pat);
    for (int k = 0; k < n; k++) begin
      wait_tick(name);
      chk($sformatf("%s_%0d", name, k), 32'(led[ch]), 32'(pat[k]));
      step();
    end
  endtask

  typedef struct {
    int ch; int mode; int per; int cnt; logic [3:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic tick_latency(input string name);
    int n;
    n = 0;
    do begin step(); n++; end while (!tick && n < 20);
    chk({name, "_first_tick"}, n, DIV);
    step();
    chk({name, "_tick_width"}, 32'(tick), 32'd0);
    n = 1;
    while (!tick && n < 20) begin step(); n++; end
    chk({name, "_tick_period"}, n, DIV);
  endtask

  initial begin
    vecs = '{
      '{1, 1, 0,   0, 4'b0010},
      '{1, 0, 0,   0, 4'b0000},
      '{5, 1, 0,   0, 4'b0000},
      '{3, 1, 0,   0, 4'b1000},
      '{7, 0, 0,   0, 4'b1000},
      '{2, 3, 100, 0, 4'b1000},
      '{2, 3, 100, 1, 4'b1100},
      '{0, 2, 'hFFFF, 0, 4'b1101},
      '{3, 0, 0,   0, 4'b0101},
      '{4, 1, 0,   0, 4'b0101},
      '{2, 0, 0,   0, 4'b0001},
      '{0, 0, 0,   0, 4'b0000}
    };

    rst = 1'b1;
    repeat (3) step();
    chk("reset_led", 32'(led), 32'd0);
    chk("reset_tick", 32'(tick), 32'd0);
    rst = 1'b0;
    tick_latency("release");

    for (int i = 0; i < 12; i++) begin
      do_write(vecs[i].ch, vecs[i].mode, vecs[i].per, vecs[i].cnt);
      chk($sformatf("vec%0d", i), 32'(led), 32'(vecs[i].exp));
    end

    do_write(1, 1, 0, 0);
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("midrst_tick", 32'(tick), 32'd0);
    chk("midrst_led", 32'(led), 32'd0);
    step();
    rst = 1'b0;
    tick_latency("midrst");

    do_write(0, 2, 3, 0);
    sample_ticks("blink3", 0, 10, 32'h1C7);
    do_write(0, 2, 3, 0);
    chk("rewrite_led", 32'(led[0]), 32'd1);
    sample_ticks("blink3_restart", 0, 4, 32'h7);
    do_write(0, 2, 0, 0);
    sample_ticks("blink_p0", 0, 4, 32'h5);

    wait_tick("collide_wait");
    do_write(3, 2, 2, 0);
    sample_ticks("collide", 3, 5, 32'h13);

    do_write(2, 3, 2, 3);
    sample_ticks("burst", 2, 19, 32'h40333);
    do_write(2, 3, 2, 0);
    sample_ticks("burst_c0", 2, 8, 32'h0);
    do_write(2, 3, 1, 1);
    sample_ticks("burst_c1", 2, 6, 32'h21);

    do_write(0, 0, 0, 0);
    do_write(1, 1, 0, 0);
    do_write(2, 2, 5, 0);
    do_write(3, 3, 1, 2);
    repeat (200 * DIV) step();

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Multi-channel, run-time programmable LED pattern generator. Replaces the fixed 1 Hz single-LED blinker.
- A shared prescaler derives a slow TICK from CLK.
- Each channel is independently set to OFF, ON, BLINK (programmable half-period) or BURST (N flashes, then a long gap).
- Sits beside the capture logic and drives board status LEDs, e.g. idle, capturing, error codes.

Parameters:
CLK_HZ, 40000000, CLK frequency in Hz
TICK_HZ, 1000, prescaler tick rate in Hz; DIV = CLK_HZ/TICK_HZ, must be >= 1
NUM_LEDS, 4, number of independent channels
PERIOD_W, 16, width of the per-channel period field, in ticks
COUNT_W, 4, width of the per-channel burst flash count
CH_W, 2, channel-select width; must satisfy 2**CH_W >= NUM_LEDS

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
WR_EN  in  1  configuration write strobe, one CLK cycle per write
WR_CH  in  CH_W  target channel
WR_MODE  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST
WR_PERIOD  in  PERIOD_W  on/off phase length in ticks
WR_COUNT  in  COUNT_W  flashes per burst
LED  out  NUM_LEDS  registered LED drive, bit i = channel i
TICK  out  1  one-cycle prescaler pulse

Behaviour:
- Reset (RESET=1 at a CLK edge): prescaler=0, TICK=0, every channel mode=OFF, period=1, count=0, phase=0, flash=0, state=S_ON, LED=0. Reset mid-pattern discards all configuration.
- Prescaler: counts 0..DIV-1 and wraps to 0.
  - TICK=1 for exactly one cycle when the count equals DIV-1, i.e. a period of DIV cycles.
  - First TICK occurs DIV cycles after reset release.
  - DIV=1 gives TICK constantly high.
- Write: when WR_EN=1 and WR_CH<NUM_LEDS, the channel latches mode, period and count at that edge. WR_PERIOD=0 is stored as 1.
  - The write also restarts the pattern: phase=0, flash=0, state=S_ON.
  - WR_CH>=NUM_LEDS: write ignored, no state change.
  - A write in the same cycle as TICK: the write wins, and the tick is not applied to that channel. Other channels advance normally.
- LED latency: LED reflects a new mode one cycle after the WR_EN edge.
  - OFF → 0; ON → 1.
  - BLINK or BURST with count>0 → 1, i.e. the pattern starts lit.
- All pattern advances happen only on TICK cycles. phase increments; on phase==period-1, phase←0 and the state transition below fires.
- OFF/ON: static; TICK has no effect.
- BLINK: each phase end toggles LED. Result is high for period ticks, low for period ticks, repeating.
- BURST: per-channel FSM with states S_ON (LED=1), S_OFF (LED=0), S_GAP (LED=0).
  - S_ON end: flash←flash+1. If flash+1==count, go to S_GAP; else go to S_OFF.
  - S_OFF end: go to S_ON.
  - S_GAP lasts 4*period ticks, counted with phase in an extended gap counter of PERIOD_W+2 bits. At its end: flash←0, go to S_ON.
  - count=0: LED held 0, FSM frozen, behaves as OFF.
  - count=1: single flash, then gap.
- Arithmetic: phase compare uses the full PERIOD_W bits; period = 2**PERIOD_W-1 is legal. No overflow or wrap beyond the compare point.
- Channels are fully independent and share only TICK.

Test Plan:
- Reset and prescaler: CLK_HZ=40, TICK_HZ=10 (DIV=4); release RESET → LED=0; TICK pulses on cycles 4, 8, 12…, each 1 cycle wide. Reassert RESET mid-run → TICK=0 and count restarts.
- ON/OFF: write ch1 mode=ON → LED[1]=1 the next cycle, other bits 0. Write ch1 mode=OFF → LED[1]=0 the next cycle. Write WR_CH=5 with NUM_LEDS=4 → no LED change.
- BLINK: ch0 mode=2, period=3 → LED[0] high for 3 ticks (12 cycles), low for 3 ticks, repeating. Rewrite mid-low-phase → LED[0]=1 the next cycle and the phase restarts. Period=0 behaves as period=1, toggling every tick.
- BURST: ch2 mode=3, period=2, count=3 → pattern (1,1,0,0)×2, then 1,1, then 8 ticks of 0, repeating. Count=0 → LED[2] stays 0 indefinitely.
- Write/TICK collision: issue a BLINK write on a TICK cycle while another channel is blinking → written channel shows phase 0 (full first high phase). Other channel's toggle timing is unchanged.
- Independence: all 4 channels in different modes simultaneously for 200 ticks → every LED bit matches its scoreboard model cycle-by-cycle.
